// File: rtl/vram_sketch_painter_pkg.sv
// Shared types for the sketch painter: display colour, touch event, painter FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_sketch_painter_pkg;

    // RGB565 pixel as consumed by the ILI9341 controller.
    typedef logic [15:0] ILI9341_color_t;
    localparam ILI9341_color_t BLACK = 16'h0000;

    // Touch event from the FT6206 front end (panel coordinates).
    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
    } touch_t;

    // Brush origin can sit left of / above the panel, so it is carried signed.
    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_PAINT = 2'd2
    } painter_state_t;

endpackage

// File: rtl/vram_sketch_painter_edge_detector.sv
// Rising-edge detector with enable: rise = din & ~din_q, din_q samples only when ena is high.
// Latency: rise is combinational from din; the history register updates one cycle later.
// Backpressure: ena low freezes the history, so an edge arriving while stalled is reported later.
// Ports: clk, rst (sync, active high), ena, din -> rise.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    always_comb begin
        din_d = din_q;
        if (ena) begin
            din_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/vram_sketch_painter.sv
// Owns the VRAM write port: full-frame clear after reset / clear press, square brush stamp per touch.
// Latency: first stamp write in the cycle after the touch is accepted; one pixel per enabled cycle.
// Backpressure: ena low holds all state and suppresses writes; busy high while clearing or stamping.
// Ports: clk, rst (sync, active high), ena, touch, clear (level), brush_color
//        -> vram_wr_ena, vram_wr_addr, vram_wr_data, busy.
module vram_sketch_painter
    import vram_sketch_painter_pkg::*;
#(
    parameter int             DISPLAY_WIDTH  = 240,
    parameter int             DISPLAY_HEIGHT = 320,
    parameter int             BRUSH_SIZE     = 4,
    parameter ILI9341_color_t CLEAR_COLOR    = BLACK,
    localparam int            VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int            AW             = $clog2(VRAM_L)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  touch_t         touch,
    input  logic           clear,
    input  ILI9341_color_t brush_color,
    output logic           vram_wr_ena,
    output logic [AW-1:0]  vram_wr_addr,
    output ILI9341_color_t vram_wr_data,
    output logic           busy
);

    localparam int               BW        = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(VRAM_L - 1);
    localparam logic [AW-1:0]    ROW_STEP  = AW'(DISPLAY_WIDTH);
    localparam logic [BW-1:0]    D_LAST    = BW'(BRUSH_SIZE - 1);
    localparam logic [COORD_W-1:0] HALF    = COORD_W'(BRUSH_SIZE / 2);

    painter_state_t             state_q,    state_d;
    logic [AW-1:0]              cnt_q,      cnt_d;
    logic signed [COORD_W-1:0]  x0_q,       x0_d;
    logic signed [COORD_W-1:0]  y0_q,       y0_d;
    logic [BW-1:0]              dx_q,       dx_d;
    logic [BW-1:0]              dy_q,       dy_d;
    logic [AW-1:0]              row_base_q, row_base_d;
    ILI9341_color_t             color_q,    color_d;

    logic                       clear_rise;
    logic signed [COORD_W-1:0]  px;
    logic signed [COORD_W-1:0]  py;
    logic                       in_range;
    logic [AW-1:0]              pix_addr;

    edge_detector u_clear_edge (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .din  (clear),
        .rise (clear_rise)
    );

    // Current brush pixel. The row base is kept modulo 2^AW: it may be "negative" or
    // oversized for clipped rows, but whenever the pixel is on-panel the wrapped sum
    // equals the true address, which is all a write needs.
    always_comb begin
        px       = x0_q + signed'(COORD_W'(dx_q));
        py       = y0_q + signed'(COORD_W'(dy_q));
        in_range = !px[COORD_W-1] && ($unsigned(px) < COORD_W'(DISPLAY_WIDTH)) &&
                   !py[COORD_W-1] && ($unsigned(py) < COORD_W'(DISPLAY_HEIGHT));
        pix_addr = row_base_q + AW'($unsigned(px));
    end

    // Write port is driven from registered state only (plus the ena gate).
    always_comb begin
        vram_wr_ena  = 1'b0;
        vram_wr_addr = cnt_q;
        vram_wr_data = CLEAR_COLOR;
        busy         = 1'b1;
        case (state_q)
            S_CLEAR: vram_wr_ena = ena;
            S_IDLE:  busy        = 1'b0;
            S_PAINT: begin
                vram_wr_ena  = ena && in_range;
                vram_wr_addr = pix_addr;
                vram_wr_data = color_q;
            end
            default: vram_wr_ena = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        row_base_d = row_base_q;
        color_d    = color_q;
        case (state_q)
            S_CLEAR: begin
                // Clear edges are ignored here: a clear never restarts itself.
                if (ena) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (ena) begin
                    if (clear_rise) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end else if (touch.valid) begin
                        state_d    = S_PAINT;
                        x0_d       = signed'({1'b0, touch.x} - HALF);
                        y0_d       = signed'({1'b0, touch.y} - HALF);
                        dx_d       = '0;
                        dy_d       = '0;
                        // One constant-coefficient product per stamp; rows after
                        // the first are reached by adding the row pitch.
                        row_base_d = AW'(int'(y0_d) * DISPLAY_WIDTH);
                        color_d    = brush_color;
                    end
                end
            end
            S_PAINT: begin
                if (ena) begin
                    if (clear_rise) begin
                        // This cycle's pixel is still written; the clear starts next cycle.
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end else if (dx_q == D_LAST) begin
                        dx_d = '0;
                        if (dy_q == D_LAST) begin
                            state_d = S_IDLE;
                        end else begin
                            dy_d       = dy_q + 1'b1;
                            row_base_d = row_base_q + ROW_STEP;
                        end
                    end else begin
                        dx_d = dx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            row_base_q <= '0;
            color_q    <= CLEAR_COLOR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            row_base_q <= row_base_d;
            color_q    <= color_d;
        end
    end

endmodule

// File: tb/tb_vram_sketch_painter.sv
// Bench for vram_sketch_painter: queue-based reference of the expected per-cycle write stream,
// checked every cycle, plus literal expectations for the documented scenarios.
// Full panel width (240) keeps the documented addresses; height is reduced to bound run time.
module tb_vram_sketch_painter;
    import vram_sketch_painter_pkg::*;

    localparam int W  = 240;
    localparam int H  = 64;
    localparam int B  = 4;
    localparam int VL = W * H;
    localparam int AW = $clog2(VL);

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    touch_t         touch;
    logic           clear;
    ILI9341_color_t brush_color;
    logic           vram_wr_ena;
    logic [AW-1:0]  vram_wr_addr;
    ILI9341_color_t vram_wr_data;
    logic           busy;

    vram_sketch_painter #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .BRUSH_SIZE     (B),
        .CLEAR_COLOR    (BLACK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .touch        (touch),
        .clear        (clear),
        .brush_color  (brush_color),
        .vram_wr_ena  (vram_wr_ena),
        .vram_wr_addr (vram_wr_addr),
        .vram_wr_data (vram_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model: queue of pending per-cycle write slots ----------------
    typedef struct {
        bit wr;
        bit is_clr;
        int addr;
        int data;
    } item_t;

    item_t mq[$];
    bit    model_valid = 0;
    bit    prev_clr    = 0;
    bit    m_rise;
    bit    m_was_paint;

    function automatic void push_clear();
        for (int a = 0; a < VL; a++) mq.push_back('{1'b1, 1'b1, a, int'(BLACK)});
    endfunction

    function automatic void push_stamp(input int tx, input int ty, input int c);
        for (int dy = 0; dy < B; dy++) begin
            for (int dx = 0; dx < B; dx++) begin
                int x = tx - B / 2 + dx;
                int y = ty - B / 2 + dy;
                bit ok = (x >= 0) && (x < W) && (y >= 0) && (y < H);
                mq.push_back('{ok, 1'b0, ok ? (y * W + x) : 0, c});
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            push_clear();
            prev_clr    = 0;
            model_valid = 1;
        end else if (model_valid && ena) begin
            m_rise   = clear && !prev_clr;
            prev_clr = clear;
            if (mq.size() > 0) begin
                m_was_paint = !mq[0].is_clr;
                void'(mq.pop_front());
                if (m_was_paint && m_rise) begin
                    mq.delete();
                    push_clear();
                end
            end else if (m_rise) begin
                push_clear();
            end else if (touch.valid) begin
                push_stamp(int'(touch.x), int'(touch.y), int'(brush_color));
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            bit exp_busy;
            bit exp_wr;
            exp_busy = mq.size() > 0;
            exp_wr   = 1'b0;
            if (exp_busy) exp_wr = ena && mq[0].wr;
            chk("cyc_wr_ena", int'(vram_wr_ena), int'(exp_wr));
            chk("cyc_busy", int'(busy), int'(exp_busy));
            if (exp_wr) begin
                chk("cyc_addr", int'(vram_wr_addr), mq[0].addr);
                chk("cyc_data", int'(vram_wr_data), mq[0].data);
            end
        end
    end

    // Log of writes actually committed at each clock edge.
    int log_a[$];
    int log_d[$];
    always @(posedge clk) begin
        if (vram_wr_ena) begin
            log_a.push_back(int'(vram_wr_addr));
            log_d.push_back(int'(vram_wr_data));
        end
    end

    function automatic int la(input int k);
        return (k >= 0 && k < log_a.size()) ? log_a[k] : -1;
    endfunction

    task automatic log_clear();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic stamp(input int x, input int y, input int c);
        touch.valid = 1'b1;
        touch.x     = 10'(x);
        touch.y     = 10'(y);
        brush_color = 16'(c);
        step(1);
        touch.valid = 1'b0;
        brush_color = 16'($urandom);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        bit t6;

        rst = 1'b1; ena = 1'b1; clear = 1'b0; touch = '0; brush_color = '0;

        // Reset state
        step(2);
        chk("rst_wr_ena", int'(vram_wr_ena), 1);
        chk("rst_addr", int'(vram_wr_addr), 0);
        chk("rst_data", int'(vram_wr_data), 0);
        chk("rst_busy", int'(busy), 1);

        // Full clear with random touch/clear noise early on, ena stall at addr 500
        rst = 1'b0;
        log_clear();
        n  = 0;
        t6 = 0;
        while (busy && n < VL + 200) begin
            step(1);
            n++;
            if (n < 400) begin
                touch.valid = 1'($urandom);
                touch.x     = 10'($urandom_range(0, 300));
                touch.y     = 10'($urandom_range(0, 100));
                clear       = 1'($urandom);
            end else begin
                touch.valid = 1'b0;
                clear       = 1'b0;
            end
            if (!t6 && busy && int'(vram_wr_addr) == 500) begin
                t6  = 1;
                ena = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    step(1);
                    chk("stall_wr_ena", int'(vram_wr_ena), 0);
                    chk("stall_addr", int'(vram_wr_addr), 500);
                end
                ena = 1'b1;
                #1;
                chk("resume_wr_ena", int'(vram_wr_ena), 1);
                chk("resume_addr", int'(vram_wr_addr), 500);
            end
        end
        chk("clear_stall_seen", int'(t6), 1);
        chk("clear_busy_end", int'(busy), 0);
        chk("clear_count", log_a.size(), VL);
        bad = 0;
        for (int k = 0; k < log_a.size(); k++)
            if (log_a[k] != k || log_d[k] != 0) bad++;
        chk("clear_sequence_bad", bad, 0);

        // Centre stamp: 16 writes starting at 48*240+98
        log_clear();
        stamp(100, 50, 16'hF800);
        chk("lat_wr_ena", int'(vram_wr_ena), 1);
        chk("lat_addr", int'(vram_wr_addr), 11618);
        chk("lat_data", int'(vram_wr_data), 16'hF800);
        wait_idle(40, n);
        chk("c_cycles", n, 16);
        chk("c_count", log_a.size(), 16);
        chk("c_last", la(15), 12341);
        bad = 0;
        for (int k = 0; k < log_a.size(); k++)
            if (log_a[k] != (48 + k / 4) * 240 + 98 + k % 4 || log_d[k] != 16'hF800) bad++;
        chk("c_pattern_bad", bad, 0);

        // Top-left corner: only 4 of 16 cycles write
        log_clear();
        stamp(0, 0, 16'h07E0);
        wait_idle(40, n);
        chk("tl_cycles", n, 16);
        chk("tl_count", log_a.size(), 4);
        chk("tl_a0", la(0), 0);
        chk("tl_a1", la(1), 1);
        chk("tl_a2", la(2), 240);
        chk("tl_a3", la(3), 241);

        // Bottom-right corner: 9 writes, nothing past the last address
        log_clear();
        stamp(W - 1, H - 1, 16'h001F);
        wait_idle(40, n);
        chk("br_cycles", n, 16);
        chk("br_count", log_a.size(), 9);
        chk("br_first", la(0), (H - 3) * W + (W - 3));
        chk("br_last", la(8), VL - 1);
        bad = 0;
        for (int k = 0; k < log_a.size(); k++) if (log_a[k] >= VL) bad++;
        chk("br_oob", bad, 0);

        // Clear edge on the 3rd stamp cycle aborts the stamp
        log_clear();
        stamp(120, 30, 16'hABCD);
        step(2);
        clear = 1'b1;
        step(1);
        chk("abort_wr_ena", int'(vram_wr_ena), 1);
        chk("abort_addr", int'(vram_wr_addr), 0);
        chk("abort_data", int'(vram_wr_data), 0);
        chk("abort_stamp_writes", log_a.size(), 3);
        chk("abort_first", la(0), 6838);
        step(3);
        clear = 1'b0;
        wait_idle(VL + 50, n);
        chk("abort_clear_count", log_a.size(), 3 + VL);
        bad = 0;
        for (int k = 3; k < log_a.size(); k++)
            if (log_a[k] != k - 3 || log_d[k] != 0) bad++;
        chk("abort_clear_bad", bad, 0);

        // Randomized touches (held and pulsed, some off-panel) with random ena
        for (int i = 0; i < 1200; i++) begin
            ena         = ($urandom_range(0, 4) != 0);
            touch.valid = 1'($urandom);
            touch.x     = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, W + 4));
            touch.y     = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, H + 4));
            brush_color = 16'($urandom);
            step(1);
        end
        ena         = 1'b1;
        touch.valid = 1'b0;
        wait_idle(40, n);

        // Reset in the middle of a stamp restarts a full clear
        stamp(50, 20, 16'h5A5A);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_addr", int'(vram_wr_addr), 0);
        chk("mid_rst_busy", int'(busy), 1);
        wait_idle(VL + 50, n);
        chk("mid_rst_clear_cycles", n, VL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
